// File: rtl/frame_aggregator.sv
`default_nettype none
// ============================================================================
// frame_aggregator : captures an OUT_W-bit field from a narrow-beat frame
// stream after SKIP_BITS and presents it on a ready/valid output.
// Option macro: FRAME_AGR_MINLEN_EN (presentation gated on MIN_BITS).
// Revision: 1.0
// ============================================================================
module frame_aggregator #(
    parameter int IN_W      = 2,
    parameter int OUT_W     = 56,
    parameter int SKIP_BITS = 0,
    parameter int MIN_BITS  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   axiid,
    input  logic              axiiv,
    output logic [OUT_W-1:0]  axiod,
    output logic              axiov,
    input  logic              axior,
    output logic              short_frame,
    output logic              drop
);

`ifdef FRAME_AGR_MINLEN_EN
    localparam int THRESH = MIN_BITS;
`else
    // MIN_BITS has no effect in this build; the zero term only keeps it referenced.
    localparam int THRESH = SKIP_BITS + OUT_W + 0 * MIN_BITS;
`endif
    localparam int CW = $clog2(THRESH + 1);

    localparam logic [CW-1:0] C_STEP   = CW'(IN_W);
    localparam logic [CW-1:0] C_THRESH = CW'(THRESH);
    localparam logic [CW-1:0] C_OUT_W  = CW'(OUT_W);
    localparam logic [CW:0]   C_SKIP   = (CW + 1)'(SKIP_BITS);

    typedef enum logic [1:0] {
        S_FLUSH = 2'd0,
        S_IDLE  = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [OUT_W-1:0]   r_shift;

    logic               w_beat;
    logic [CW:0]        w_rel;
    logic               w_in_win;
    logic [OUT_W-1:0]   w_shifted;
    logic [OUT_W-1:0]   w_cap;
    logic [CW-1:0]      w_cnt_sum;
    logic               w_trigger;
    logic               w_free;

    generate
        if (OUT_W > IN_W) begin : g_shift_wide
            assign w_shifted = {r_shift[OUT_W-IN_W-1:0], axiid};
        end else begin : g_shift_beat
            assign w_shifted = axiid;
        end
    endgenerate

    // Window test done as an offset from SKIP_BITS so a zero skip needs no special case.
    assign w_beat    = axiiv && ((r_state == S_IDLE) || (r_state == S_RUN));
    assign w_rel     = {1'b0, r_cnt} - C_SKIP;
    assign w_in_win  = !w_rel[CW] && (w_rel[CW-1:0] < C_OUT_W);
    assign w_cap     = w_in_win ? w_shifted : r_shift;
    assign w_cnt_sum = r_cnt + C_STEP;
    assign w_trigger = w_beat && (w_cnt_sum >= C_THRESH);
    assign w_free    = !axiov || axior;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FLUSH;
            r_cnt       <= '0;
            r_shift     <= '0;
            axiod       <= '0;
            axiov       <= 1'b0;
            short_frame <= 1'b0;
            drop        <= 1'b0;
        end else begin
            short_frame <= 1'b0;
            drop        <= 1'b0;

            case (r_state)
                S_FLUSH: begin
                    if (!axiiv) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (axiiv) begin
                        r_cnt   <= w_cnt_sum;
                        r_state <= w_trigger ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (axiiv) begin
                        r_cnt <= w_cnt_sum;
                        if (w_trigger) begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        short_frame <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (!axiiv) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_FLUSH;
                end
            endcase

            if (w_beat) begin
                r_shift <= w_cap;
            end

            if (w_trigger) begin
                if (w_free) begin
                    axiod <= w_cap;
                    axiov <= 1'b1;
                end else begin
                    drop <= 1'b1;
                end
            end else if (axiov && axior) begin
                axiov <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_aggregator.sv
`default_nettype none
// Directed bench for frame_aggregator: a default instance and a skip/narrow instance
// share one dibit stream and are checked against a frame-level model every cycle.
module tb_frame_aggregator;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        axiiv = 1'b0;
    logic        axior = 1'b1;
    logic [1:0]  axiid = 2'd0;

    logic [55:0] d0;
    logic        v0, s0, dr0;
    logic [15:0] d1;
    logic        v1, s1, dr1;

    always #5 clk = ~clk;

`ifdef FRAME_AGR_MINLEN_EN
    localparam int THR0 = 64;
    localparam int THR1 = 32;
    localparam int TRIG0_SEEN = 32;
`else
    localparam int THR0 = 56;
    localparam int THR1 = 24;
    localparam int TRIG0_SEEN = 28;
`endif

    frame_aggregator #(.IN_W(2), .OUT_W(56), .SKIP_BITS(0), .MIN_BITS(64)) dut0 (
        .clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv),
        .axiod(d0), .axiov(v0), .axior(axior), .short_frame(s0), .drop(dr0)
    );

    frame_aggregator #(.IN_W(2), .OUT_W(16), .SKIP_BITS(8), .MIN_BITS(32)) dut1 (
        .clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv),
        .axiod(d1), .axiov(v1), .axior(axior), .short_frame(s1), .drop(dr1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: beat index, window membership and output hand-off.
    int          m_skip[2] = '{0, 8};
    int          m_outw[2] = '{56, 16};
    int          m_thr[2]  = '{THR0, THR1};
    bit          armed[2];
    int          nb[2];
    bit          done_f[2];
    logic [63:0] fld[2];
    logic [63:0] ed[2];
    bit          ev[2], es[2], edr[2];
    bit          started = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                armed[i] = 0; nb[i] = 0; done_f[i] = 0; fld[i] = 0;
                ed[i] = 0; ev[i] = 0; es[i] = 0; edr[i] = 0;
            end else begin
                bit t;
                t = 0; es[i] = 0; edr[i] = 0;
                if (!armed[i]) begin
                    if (!axiiv) armed[i] = 1;
                end else if (axiiv) begin
                    if (!done_f[i]) begin
                        if (nb[i] * 2 >= m_skip[i] && nb[i] * 2 < m_skip[i] + m_outw[i])
                            fld[i] = ((fld[i] << 2) | 64'(axiid)) & ((64'd1 << m_outw[i]) - 1);
                        nb[i]++;
                        if (nb[i] * 2 == m_thr[i]) begin
                            t = 1; done_f[i] = 1;
                        end
                    end
                end else begin
                    if (nb[i] > 0 && !done_f[i]) es[i] = 1;
                    nb[i] = 0; done_f[i] = 0;
                end
                if (t) begin
                    if (!ev[i] || axior) begin ed[i] = fld[i]; ev[i] = 1; end
                    else edr[i] = 1;
                end else if (ev[i] && axior) begin
                    ev[i] = 0;
                end
            end
        end
    end

    int drops0 = 0, drops1 = 0;

    always @(negedge clk) begin
        if (started) begin
            check("axiov0", 64'(v0), 64'(ev[0]));
            check("axiod0", 64'(d0), ed[0]);
            check("short0", 64'(s0), 64'(es[0]));
            check("drop0",  64'(dr0), 64'(edr[0]));
            check("axiov1", 64'(v1), 64'(ev[1]));
            check("axiod1", 64'(d1), ed[1]);
            check("short1", 64'(s1), 64'(es[1]));
            check("drop1",  64'(dr1), 64'(edr[1]));
            drops0 += int'(dr0);
            drops1 += int'(dr1);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            axiiv = 1'b0;
            axiid = 2'd0;
        end
    endtask

    task automatic beat(input logic [1:0] d);
        @(negedge clk);
        axiiv = 1'b1;
        axiid = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_v;
        int snap0, snap1;

        repeat (3) @(negedge clk);
        check("reset_axiov0", 64'(v0), 64'd0);
        check("reset_axiod0", 64'(d0), 64'd0);
        rst = 1'b0;
        idle(3);

        // Frame A: 3,2,1,0 repeating, output held so the first value stays visible
        axior = 1'b0;
        first_v = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (first_v < 0 && v0) first_v = i;
            axiiv = 1'b1;
            axiid = 2'(3 - (i % 4));
        end
        idle(1);
        check("latency0", 64'(first_v), 64'(TRIG0_SEEN));
        check("fieldA0", 64'(d0), 64'h00E4E4E4E4E4E4E4);
        check("fieldA1", 64'(d1), 64'h000000000000E4E4);
        @(negedge clk);
        axior = 1'b1;
        @(negedge clk);
        check("accept_clears0", 64'(v0), 64'd0);

        // Frame B: 4 x 0, 8 x 1, 4 x 0 -> runt for dut0, 16'h5555 for dut1
        for (int i = 0; i < 16; i++) beat((i >= 4 && i < 12) ? 2'd1 : 2'd0);
        idle(1);
        @(negedge clk);
        check("short_pulse0", 64'(s0), 64'd1);
        check("fieldB1", 64'(d1), 64'h0000000000005555);
        idle(2);

        // Back-pressure: two qualifying frames while downstream is stalled
        axior = 1'b0;
        snap0 = drops0; snap1 = drops1;
        for (int i = 0; i < 40; i++) beat(2'd2);
        idle(1);
        for (int i = 0; i < 40; i++) beat(2'd1);
        idle(3);
        check("drop_count0", 64'(drops0 - snap0), 64'd1);
        check("drop_count1", 64'(drops1 - snap1), 64'd1);
        check("held_value0", 64'(d0), 64'h00AAAAAAAAAAAAAA);
        @(negedge clk);
        axior = 1'b1;
        @(negedge clk);
        check("release_clears0", 64'(v0), 64'd0);
        idle(2);

        // Accept coincides with the next trigger on dut0
        axior = 1'b0;
        for (int i = 0; i < 40; i++) beat(2'(3 - (i % 4)));
        idle(1);
        snap0 = drops0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            axiiv = 1'b1;
            axiid = 2'd1;
            axior = (i == TRIG0_SEEN - 1);
        end
        idle(2);
        check("reload_valid0", 64'(v0), 64'd1);
        check("reload_value0", 64'(d0), 64'h0055555555555555);
        check("reload_nodrop0", 64'(drops0 - snap0), 64'd0);
        axior = 1'b1;
        idle(3);

        // Reset in mid-frame, released while the frame is still running
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 11) begin
                check("midreset_axiov0", 64'(v0), 64'd0);
                check("midreset_axiod0", 64'(d0), 64'd0);
            end
            rst   = (i == 10 || i == 11);
            axiiv = 1'b1;
            axiid = 2'd2;
        end
        idle(1);
        @(negedge clk);
        check("flush_noshort0", 64'(s0), 64'd0);
        check("flush_novalid0", 64'(v0), 64'd0);
        for (int i = 0; i < 40; i++) beat(2'd2);
        idle(2);
        check("after_reset0", 64'(d0), 64'h00AAAAAAAAAAAAAA);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_aggregator.md
# frame_aggregator

Parametrised front-end aggregator for the Ethernet interface: collects a fixed-width header field from an incoming narrow-beat frame stream (RMII dibits by default), optionally skipping leading bits, and presents it once per frame on a ready/valid output. Successor to the fixed 56-bit/2-bit aggregator. Adds skip offset, output back-pressure, a short-frame indication and a dropped-frame indication. Sits between the RMII receive/FCS stage and the Manta message decoder.

## Interface
- `IN_W`, 2: bits per input beat.
- `OUT_W`, 56: captured field width; multiple of `IN_W`.
- `SKIP_BITS`, 0: frame bits discarded before capture starts; multiple of `IN_W`.
- `MIN_BITS`, 64: minimum frame length for qualification (used only with `FRAME_AGR_MINLEN_EN`); multiple of `IN_W`, ≥ `SKIP_BITS+OUT_W`.
- `clk`  in  1  single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `axiid`  in  `IN_W`  input beat; first-received bit pair is most significant.
- `axiiv`  in  1  high for every beat of a frame; a low cycle ends the frame.
- `axiod`  out  `OUT_W`  captured field, MSB = earliest captured beat.
- `axiov`  out  1  output valid; held until accepted.
- `axior`  in  1  output ready from downstream.
- `short_frame`  out  1  one-cycle pulse: frame ended before qualifying.
- `drop`  out  1  one-cycle pulse: qualified frame discarded due to back-pressure.

## Operation
- THRESH = `SKIP_BITS+OUT_W` (macro off) or `MIN_BITS` (macro on).
- Bit counter `cnt`: clears when frame ends; +`IN_W` per beat in RUN; saturates at THRESH.
- Capture: a beat with pre-beat `cnt` in [`SKIP_BITS`, `SKIP_BITS+OUT_W`) shifts in at LSB of an internal shift register (shift left by `IN_W`). Beats outside the window are ignored.
- FSM states:
  - FLUSH (reset state): ignore beats; `axiiv`=0 → IDLE. Prevents capture of a frame already in progress at reset release.
  - IDLE: `axiiv`=1 → RUN; that beat is counted/captured (beat 0).
  - RUN: beat bringing `cnt` to THRESH → trigger, DONE. `axiiv`=0 → `short_frame` pulse, IDLE.
  - DONE: beats ignored; `axiiv`=0 → IDLE. At most one trigger per frame.
- Trigger with output free (`axiov`=0, or `axiov`=1 and `axior`=1 same cycle): load `axiod` from shift register (including the triggering beat if in window), `axiov`=1.
- Trigger with `axiov`=1 and `axior`=0: `drop` pulse; `axiod`/`axiov` unchanged.
- `axiov`=1 and `axior`=1 with no trigger: `axiov`→0; `axiod` holds last value.
- `axiod` must not change while `axiov`=1 except on simultaneous accept+reload.
- Shift register is not cleared between frames; only windowed beats reach `axiod`.

## Timing
- Reset: `axiod`=0, `axiov`=0, `short_frame`=0, `drop`=0, `cnt`=0, shift register 0, state FLUSH; effective the cycle after `rst` sampled high. Reset mid-frame abandons frame, no pulses.
- Latency: `axiov` rises the cycle after the triggering beat's edge. Defaults, macro off: beats 0..27 captured, `axiov` high after beat 27. Macro on: after beat 31.
- `short_frame` and `drop` are registered, asserted the cycle after the causing edge, one cycle wide.
- Back-to-back frames separated by a single `axiiv`=0 cycle are fully supported.
- Frame shorter than `SKIP_BITS` ends → `short_frame` still pulses (if ≥1 beat).

## Configuration
- `FRAME_AGR_MINLEN_EN` defined: THRESH = `MIN_BITS`; field captured as before but presented only once the frame reaches `MIN_BITS` (discards FCS-only/runt frames); frames between `SKIP_BITS+OUT_W` and `MIN_BITS` bits produce `short_frame`, no `axiov`.
- Undefined: THRESH = `SKIP_BITS+OUT_W`; `MIN_BITS` ignored.

## Test plan
- Defaults, macro off, `axior`=1: 40-beat frame of dibits 3,2,1,0 repeating → `axiov` one cycle after beat 27, `axiod`=56'hE4E4E4E4E4E4E4; single trigger.
- Macro on, 30-beat frame → no `axiov`, `short_frame` pulse one cycle after `axiiv` falls; 32-beat frame → `axiov` after beat 31.
- `SKIP_BITS`=8, `OUT_W`=16, beats 4×0 then 8×dibit 1 → `axiod`=16'h5555.
- `axior`=0 held, two qualifying frames → first value held, `drop` pulses once at second trigger; then `axior`=1 → `axiov` drops next cycle.
- Trigger cycle coincides with `axior`=1 on pending output → new value loaded, `axiov` stays 1, no `drop`.
- `rst` asserted at beat 10, released with `axiiv` still high → frame ignored until `axiiv` low; next frame captured normally; all outputs 0 during reset.
